// File: rtl/mul_div_unit_if.sv
// Handshake/result bundle between the execute stage and the iterative multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, sign fix-up.
// Optional macro MDU_FAST_ZERO_EN skips the iteration phase when an operand makes the result trivial.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_res, a_neg, div_zero;

  logic               accept, fast_zero, last_iter;
  logic               signed_op, a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept    = (state == IDLE) && bus.start && !bus.cancel;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign signed_op = ~bus.op[0];
  assign a_neg_in  = signed_op & bus.a[WIDTH-1];
  assign b_neg_in  = signed_op & bus.b[WIDTH-1];
  assign a_mag_in  = a_neg_in ? -bus.a : bus.a;
  assign b_mag_in  = b_neg_in ? -bus.b : bus.b;

`ifdef MDU_FAST_ZERO_EN
  assign fast_zero = bus.op[1] ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`else
  assign fast_zero = 1'b0;
`endif

  // Multiply keeps {partial_hi, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opnd};
  assign prod_fix  = -acc;

  always_comb begin
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!div_trial[WIDTH+1])
        acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    if (!is_div) begin
      if (neg_res) {res_hi, res_lo} = prod_fix;
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      if (neg_res) res_lo = -acc[WIDTH-1:0];
      if (a_neg)   res_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = fast_zero ? FIX : RUN;
      RUN:  if (bus.cancel) state_next = IDLE;
            else if (last_iter) state_next = FIX;
      FIX:  state_next = bus.cancel ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      a_neg    <= 1'b0;
      div_zero <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      if (accept) begin
        is_div   <= bus.op[1];
        neg_res  <= a_neg_in ^ b_neg_in;
        a_neg    <= a_neg_in;
        div_zero <= bus.op[1] && (bus.b == '0);
        a_raw    <= bus.a;
        cnt      <= '0;
        opnd     <= bus.op[1] ? b_mag_in : a_mag_in;
        if (fast_zero)      acc <= '0;
        else if (bus.op[1]) acc <= {{WIDTH{1'b0}}, a_mag_in};
        else                acc <= {{WIDTH{1'b0}}, b_mag_in};
      end else if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !bus.cancel) begin
        bus.hi <= res_hi;
        bus.lo <= res_lo;
      end
    end
  end

endmodule
